// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with optional overlap and hit count.
// Optional hit counter port and logic: define SEQ_DETECT_HITCNT_EN.
module seq_detect_param #(
    parameter int             N       = 5,
    parameter logic [N-1:0]   PATTERN = N'(5'b10101),
    parameter int             OVERLAP = 0,
    parameter int             CW      = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          d_in,
    output logic          y_out
`ifdef SEQ_DETECT_HITCNT_EN
    ,
    output logic [CW-1:0] hit_cnt
`endif
);

    localparam int             FW   = $clog2(N + 1);
    localparam logic [FW-1:0]  FULL = FW'(N);

    logic [N-1:0]  hist;
    logic [N-1:0]  hist_nx;
    logic [FW-1:0] fill;
    logic [FW-1:0] fill_inc;
    logic [FW-1:0] fill_nx;
    logic          match;

    // Shift in the accepted bit, saturate the fill count, flag a full match.
    always_comb begin
        hist_nx  = hist;
        fill_inc = fill;
        fill_nx  = fill;
        match    = 1'b0;
        if (en) begin
            hist_nx  = {hist[N-2:0], d_in};
            fill_inc = (fill == FULL) ? FULL : fill + 1'b1;
            match    = (fill_inc == FULL) && (hist_nx == PATTERN);
            fill_nx  = (match && OVERLAP == 0) ? '0 : fill_inc;
        end
    end

    // History, fill and Moore flag advance only on accepted samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= '0;
            fill  <= '0;
            y_out <= 1'b0;
        end else if (en) begin
            hist  <= hist_nx;
            fill  <= fill_nx;
            y_out <= match;
        end
    end

`ifdef SEQ_DETECT_HITCNT_EN
    // Count matches, sticking at the all-ones value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt <= '0;
        end else if (match && hit_cnt != '1) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter N, default 5, pattern length in bits; legal range 2..32.
REQ-002 SHALL have parameter PATTERN, default 5'b10101, N bits wide; the MSB is the first bit received.
REQ-003 SHALL have parameter OVERLAP, default 0; 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CW, default 8, hit counter width; legal range 1..32.
REQ-005 SHALL have port clk, input, 1 bit; single clock, rising-edge active.
REQ-006 SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-007 SHALL have port en, input, 1 bit; sample qualifier; d_in is accepted only on rising edges where en=1.
REQ-008 SHALL have port d_in, input, 1 bit; serial data bit.
REQ-009 SHALL have port y_out, output, 1 bit; registered Moore detect flag.
REQ-010 SHALL have port hit_cnt, output, CW bits; detection count; present only when SEQ_DETECT_HITCNT_EN is defined.

Function
REQ-011 SHALL keep an N-bit history register hist (newest bit in LSB) and a fill counter fill (0..N) of valid bits since reset or the last non-overlap restart.
REQ-012 On an accepted sample: hist SHALL become {hist[N-2:0], d_in}, and fill SHALL become min(fill+1, N).
REQ-013 A match SHALL occur on an accepted sample when the updated fill equals N and the updated hist equals PATTERN.
REQ-014 y_out SHALL be 1 from the edge that accepts the final pattern bit until the next accepted sample; otherwise it SHALL be 0 (Moore behaviour, 0-cycle latency after the sampling edge, no combinational path from d_in).
REQ-015 With en=0, hist, fill, y_out and hit_cnt SHALL hold their values.
REQ-016 OVERLAP=1: after a match, fill SHALL stay N, so the pattern's suffix bits may begin the next match.
REQ-017 OVERLAP=0: on a match, fill SHALL be cleared to 0 on the same edge, so no bit of a matched pattern contributes to a later match.
REQ-018 Bits arriving before fill reaches N SHALL never produce a match, including an all-zero PATTERN directly after reset.
REQ-019 Back-to-back matches on consecutive accepted samples (possible only with OVERLAP=1 and a periodic pattern such as all-ones) SHALL keep y_out high across both samples.

Reset
REQ-020 Asserting rst SHALL immediately force hist=0, fill=0, y_out=0 and hit_cnt=0, regardless of clk or en.
REQ-021 Reset mid-pattern SHALL discard all partial progress; detection after deassertion SHALL require N fresh accepted bits.
REQ-022 The first accepted sample SHALL be the first rising edge with en=1 after rst deasserts.

Configuration
REQ-023 With macro SEQ_DETECT_HITCNT_EN defined, hit_cnt SHALL increment by 1 on each edge that produces a match and saturate at 2^CW-1.
REQ-024 Without SEQ_DETECT_HITCNT_EN, the hit_cnt port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-025 Defaults, OVERLAP=0, en=1, d_in 1,0,1,0,1,0,1 -> y_out=1 only after the 5th bit; no detection after the 7th bit.
REQ-026 Defaults, OVERLAP=1, same stream 1010101 -> y_out=1 after the 5th and 7th bits; hit_cnt=2 with the macro defined.
REQ-027 OVERLAP=0, stream 1010110101 with en=1 -> y_out=1 after bits 5 and 10; hit_cnt=2.
REQ-028 Stream 1,0,1 then en=0 for 3 cycles with d_in toggling, then 0,1 with en=1 -> single match on the final bit; y_out holds 0 while en=0.
REQ-029 Stream 1,0,1,0, then pulse rst between edges, then 1 -> no match; then 0,1,0,1 -> still no match until 10101 has been fully re-received.
REQ-030 N=3, PATTERN=3'b111, OVERLAP=1, CW=2, 8 ones -> y_out high from bit 3 through bit 8; hit_cnt saturates at 3.
